sprite_eval_ctrl: RTL
=====================

# sprite_eval_ctrl

Per-scanline sprite evaluation sequencer for the PPU. It drives the primary 256-byte OAM read address and the 32-byte secondary OAM write port. On each rendering scanline it clears secondary OAM, then scans all 64 primary sprites and copies up to 8 in-range sprites into secondary OAM for the next line's sprite fetch. It also produces the sprite-overflow and sprite-zero-present flags that feed PPUSTATUS and sprite-0-hit logic.

## Interface
- SPR_COUNT, 64: sprites in primary OAM.
- SEC_SLOTS, 8: sprite slots in secondary OAM.
- clock  in  1  PPU master clock.
- reset_n  in  1  asynchronous active-low reset.
- clock_EN  in  1  dot enable; all state advances only when high.
- dot  in  9  current dot, 0..340.
- scanline  in  9  current scanline, 0..261 (261 = pre-render).
- render_en  in  1  background or sprite rendering enabled.
- tall_sprites  in  1  PPUCTRL bit 5 (8x16 sprites).
- cpu_oam_addr  in  8  OAMADDR register value.
- oam_rdata  in  8  primary OAM dataOut (combinational read).
- oam_addr  out  8  primary OAM address.
- sec_addr  out  5  secondary OAM address.
- sec_write  out  1  secondary OAM write strobe.
- sec_wdata  out  8  secondary OAM write data.
- sprite_count  out  4  sprites found for the next line, 0..8.
- sprite_zero_next  out  1  sprite 0 is among the next line's sprites.
- sprite_overflow  out  1  PPUSTATUS bit 5.
- eval_done  out  1  secondary OAM is stable for the fetch phase.

## Operation
- Evaluation runs only when render_en=1 and scanline is 0..239. Otherwise the state is IDLE, oam_addr=cpu_oam_addr, and sec_write=0.
- States are IDLE, CLEAR, EVAL_Y, EVAL_COPY, OVF_SCAN, DONE.
- Counters: n (6-bit sprite index), m (2-bit byte index), found (4-bit slot count), and clr (5-bit clear index).
- CLEAR covers dots 1..64.
  - Odd dots are idle.
  - Even dot d writes sec_addr=d/2-1 with sec_wdata=8'hFF.
- EVAL runs from dot 65 to dot 256. Odd dots present an address and latch oam_rdata. Even dots act on the latched byte.
- EVAL_Y:
  - The odd dot presents oam_addr={n,2'b00}.
  - The even dot writes the Y byte to sec[{found[2:0],2'b00}].
  - Range test: diff=scanline−Y, computed 9-bit unsigned. In range iff diff < (tall_sprites ? 16 : 8).
  - In range: go to EVAL_COPY with m=1. If n=0, set sprite_zero_next.
  - Not in range: n increments. The slot is overwritten later.
- EVAL_COPY copies bytes m=1..3 of sprite n, one byte per odd/even dot pair.
  - After m=3: found increments, n increments, m=0.
  - If found reaches SEC_SLOTS, go to OVF_SCAN; otherwise return to EVAL_Y.
- OVF_SCAN makes no secondary writes.
  - Each odd dot reads {n,m}.
  - In range: set sprite_overflow and go to DONE.
  - Not in range: n increments and m behaves per Configuration.
- Incrementing n past 63 (wrap to 0) from any EVAL state goes to DONE.
- DONE holds until dot 257. At dot 257, eval_done=1 and sprite_count=found. Both are held until dot 0 of the next line.
- sprite_zero_next and sprite_count are latched at dot 257. Their working copies reset at dot 0.
- At dot 1 of scanline 261, sprite_overflow clears. It is not cleared anywhere else except by reset.

## Timing
- Reset values: oam_addr=0, sec_addr=0, sec_write=0, sec_wdata=0, sprite_count=0, sprite_zero_next=0, sprite_overflow=0, eval_done=0. State resets to IDLE.
- Reset mid-evaluation aborts immediately. Secondary OAM contents are undefined until the next CLEAR.
- oam_addr, sec_addr and sec_write are registered. They change one clock after the clock_EN edge of the dot that decides them, and are valid during the following dot.
- Worst-case EVAL uses 64·2 + 8·6 = 176 dots. DONE is always reached by dot 240.
- render_en dropping mid-line forces IDLE at the next clock_EN. Flags keep their values.
- Y values 240..255 never match lines 0..239, because 9-bit diff ≥ 16.

## Configuration
- SPRITE_OVF_BUG_EN defined: OVF_SCAN reproduces the hardware bug. On a miss, both n and m increment (m wraps 3→0 without carry). False positives and negatives match the 2C02.
- Undefined: OVF_SCAN keeps m=0 and tests only Y bytes, giving exact overflow detection.

## Structure
- Package ppu_pkg holds:
  - the state enum eval_state_t;
  - the constants SPR_H8=8, SPR_H16=16, CLEAR_END_DOT=64, EVAL_END_DOT=256, FETCH_DOT=257, PRERENDER_LINE=261.
- Range comparison sits in one sub-module, sprite_range_cmp (scanline, Y, tall → hit). It is shared by the EVAL_Y and OVF_SCAN paths.

## Test plan
- Scanline 10, all Y=8'hF8 → sec OAM all 8'hFF after dot 64, sprite_count=0, sprite_overflow=0.
- Sprite 0 Y=5, tile 8'h11, attr 8'h22, X 8'h33; scanline 10, 8x8 → sec[0..3]=05,11,22,33, sprite_count=1, sprite_zero_next=1.
- Nine sprites with Y=20 on scanline 22 → sprite_count=8, sprite_overflow=1, sec holds sprites 0..7, sprite 8 not written.
- tall_sprites=1, Y=100, scanlines 115 and 116 → hit on 115, miss on 116.
- Eight sprites in range plus sprite 9 with Y=200, and sprite 10 whose byte 1 equals the scanline → sprite_overflow=1 only with SPRITE_OVF_BUG_EN defined.
- Assert reset_n at dot 150 mid-copy → all outputs return to reset values. sprite_overflow set on line N → cleared at scanline 261 dot 1.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared types and dot/line constants for the PPU sprite evaluation logic.
package ppu_pkg;

   localparam int SPR_COUNT = 64;
   localparam int SEC_SLOTS = 8;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      EVAL_Y,
      EVAL_COPY,
      OVF_SCAN,
      DONE
   } eval_state_t;

   localparam logic [8:0] SPR_H8         = 9'd8;
   localparam logic [8:0] SPR_H16        = 9'd16;
   localparam logic [8:0] CLEAR_END_DOT  = 9'd64;
   localparam logic [8:0] EVAL_END_DOT   = 9'd256;
   localparam logic [8:0] FETCH_DOT      = 9'd257;
   localparam logic [8:0] PRERENDER_LINE = 9'd261;
   localparam logic [8:0] VISIBLE_LINES  = 9'd240;

endpackage

// File: rtl/sprite_range_cmp.sv
// Vertical range test: sprite row = scanline - Y in 9-bit unsigned, so Y >= 240 never matches.
module sprite_range_cmp
   import ppu_pkg::*;
(
   input  logic [8:0] scanline,
   input  logic [7:0] y,
   input  logic       tall,
   output logic       hit
);

   logic [8:0] diff;

   assign diff = scanline - {1'b0, y};
   assign hit  = diff < (tall ? SPR_H16 : SPR_H8);

endmodule

// File: rtl/sprite_eval_ctrl.sv
// Sprite evaluation: clears secondary OAM, copies up to 8 in-range sprites, flags overflow and sprite 0.
// Outputs registered one dot after the deciding clock_EN edge; no backpressure. SPRITE_OVF_BUG_EN selects the 2C02 overflow-scan bug.
module sprite_eval_ctrl
   import ppu_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       clock_EN,
   input  logic [8:0] dot,
   input  logic [8:0] scanline,
   input  logic       render_en,
   input  logic       tall_sprites,
   input  logic [7:0] cpu_oam_addr,
   input  logic [7:0] oam_rdata,
   output logic [7:0] oam_addr,
   output logic [4:0] sec_addr,
   output logic       sec_write,
   output logic [7:0] sec_wdata,
   output logic [3:0] sprite_count,
   output logic       sprite_zero_next,
   output logic       sprite_overflow,
   output logic       eval_done
);

   eval_state_t state;
   logic [5:0]  n;
   logic [1:0]  m;
   logic [3:0]  found;
   logic [4:0]  clr;
   logic [7:0]  byte_q;
   logic        szn_work;
   logic        hit;
   logic        active;
   logic        last_spr;

   assign active   = render_en && (scanline < VISIBLE_LINES);
   assign last_spr = (n == 6'(SPR_COUNT - 1));

   sprite_range_cmp u_range (
      .scanline (scanline),
      .y        (byte_q),
      .tall     (tall_sprites),
      .hit      (hit)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         n                <= 6'd0;
         m                <= 2'd0;
         found            <= 4'd0;
         clr              <= 5'd0;
         byte_q           <= 8'd0;
         szn_work         <= 1'b0;
         oam_addr         <= 8'd0;
         sec_addr         <= 5'd0;
         sec_write        <= 1'b0;
         sec_wdata        <= 8'd0;
         sprite_count     <= 4'd0;
         sprite_zero_next <= 1'b0;
         sprite_overflow  <= 1'b0;
         eval_done        <= 1'b0;
      end else if (clock_EN) begin
         sec_write <= 1'b0;
         if (dot == 9'd0) eval_done <= 1'b0;
         if (dot == 9'd1 && scanline == PRERENDER_LINE) sprite_overflow <= 1'b0;

         if (!active) begin
            state    <= IDLE;
            oam_addr <= cpu_oam_addr;
         end else if (dot == 9'd0) begin
            state    <= CLEAR;
            n        <= 6'd0;
            m        <= 2'd0;
            found    <= 4'd0;
            clr      <= 5'd0;
            szn_work <= 1'b0;
            oam_addr <= 8'd0;
         end else begin
            case (state)
               IDLE: oam_addr <= cpu_oam_addr;
               CLEAR: begin
                  if (!dot[0]) begin
                     sec_write <= 1'b1;
                     sec_addr  <= clr;
                     sec_wdata <= 8'hFF;
                     clr       <= clr + 5'd1;
                     if (dot == CLEAR_END_DOT) state <= EVAL_Y;
                  end
               end
               EVAL_Y, EVAL_COPY, OVF_SCAN: begin
                  // Odd dots latch the presented byte; even dots act on it and set up the next address.
                  if (dot > EVAL_END_DOT) begin
                     state <= DONE;
                  end else if (dot[0]) begin
                     byte_q <= oam_rdata;
                  end else if (state == EVAL_Y) begin
                     sec_write <= 1'b1;
                     sec_addr  <= {found[2:0], 2'b00};
                     sec_wdata <= byte_q;
                     if (hit) begin
                        if (n == 6'd0) szn_work <= 1'b1;
                        m        <= 2'd1;
                        oam_addr <= {n, 2'b01};
                        state    <= EVAL_COPY;
                     end else begin
                        n        <= n + 6'd1;
                        oam_addr <= {n + 6'd1, 2'b00};
                        if (last_spr) state <= DONE;
                     end
                  end else if (state == EVAL_COPY) begin
                     sec_write <= 1'b1;
                     sec_addr  <= {found[2:0], m};
                     sec_wdata <= byte_q;
                     if (m == 2'd3) begin
                        found    <= found + 4'd1;
                        n        <= n + 6'd1;
                        m        <= 2'd0;
                        oam_addr <= {n + 6'd1, 2'b00};
                        if (last_spr)                        state <= DONE;
                        else if (found == 4'(SEC_SLOTS - 1)) state <= OVF_SCAN;
                        else                                 state <= EVAL_Y;
                     end else begin
                        m        <= m + 2'd1;
                        oam_addr <= {n, m + 2'd1};
                     end
                  end else begin
                     if (hit) begin
                        sprite_overflow <= 1'b1;
                        state           <= DONE;
                     end else begin
                        n <= n + 6'd1;
`ifdef SPRITE_OVF_BUG_EN
                        // The byte index drifts with every miss, so later tests look at tile/attr/X bytes.
                        m        <= m + 2'd1;
                        oam_addr <= {n + 6'd1, m + 2'd1};
`else
                        oam_addr <= {n + 6'd1, m};
`endif
                        if (last_spr) state <= DONE;
                     end
                  end
               end
               DONE: begin
                  if (dot == FETCH_DOT) begin
                     eval_done        <= 1'b1;
                     sprite_count     <= found;
                     sprite_zero_next <= szn_work;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
